// File: rtl/mem_wb_writeback_pkg.sv
// Shared types for the MEM/WB writeback slice: FSM state encoding, default widths
// and the writeback result-select encoding {memtoreg, link}.
package mem_wb_writeback_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int ADDR_W_DEF  = 5;
  localparam int TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_LD = 2'd1,
    ST_WRITE   = 2'd2
  } wb_state_e;

  typedef enum logic [1:0] {
    SEL_ALU        = 2'b00,
    SEL_PC4        = 2'b01,
    SEL_RDATA      = 2'b10,
    SEL_RDATA_LINK = 2'b11
  } wb_sel_e;

  function automatic wb_sel_e wb_sel_encode(input logic memtoreg, input logic link);
    return wb_sel_e'({memtoreg, link});
  endfunction

  // Load data wins over link when both are set.
  function automatic logic [2:0] wb_sel_onehot(input wb_sel_e sel);
    logic [2:0] hot;
    hot = 3'b000;
    case (sel)
      SEL_ALU:        hot = 3'b001;
      SEL_PC4:        hot = 3'b010;
      SEL_RDATA:      hot = 3'b100;
      SEL_RDATA_LINK: hot = 3'b100;
      default:        hot = 3'b001;
    endcase
    return hot;
  endfunction

endpackage

// File: rtl/mem_wb_writeback_wb_select.sv
// 3:1 writeback result mux (ALU result, return address, load data), built as a
// per-bit one-hot AND-OR so it maps onto plain LUTs.
module mem_wb_writeback_wb_select
  import mem_wb_writeback_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  wb_sel_e           sel_i,
  input  logic [DATA_W-1:0] alu_i,
  input  logic [DATA_W-1:0] pc4_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [DATA_W-1:0] data_o
);

  logic [2:0] hot;

  assign hot = wb_sel_onehot(sel_i);

  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_bit
      assign data_o[gi] = (hot[0] & alu_i[gi])
                        | (hot[1] & pc4_i[gi])
                        | (hot[2] & rdata_i[gi]);
    end
  endgenerate

endmodule

// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register with load-response wait FSM and timeout. Produces the
// register-file write bundle and stalls EX/MEM while a load response is pending.
module mem_wb_writeback
  import mem_wb_writeback_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              ex_regwrite,
  input  logic              ex_memtoreg,
  input  logic              ex_link,
  input  logic [ADDR_W-1:0] ex_destadd,
  input  logic [DATA_W-1:0] ex_aluresult,
  input  logic [DATA_W-1:0] ex_pcplus4,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              flush,
  output logic              stall_out,
  output logic              mem_wb_regwrite,
  output logic [ADDR_W-1:0] mem_wb_destadd,
  output logic [DATA_W-1:0] wb_writedata,
  output logic              load_timeout
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  wb_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] ld_dest_q, ld_dest_d;
  logic              ld_regwrite_q, ld_regwrite_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] dest_q, dest_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              timeout_q, timeout_d;

  wb_sel_e           sel;
  logic [DATA_W-1:0] sel_data;
  logic              accept;

  // While waiting, the mux is pinned to load data so the capture path is direct.
  assign sel = (state_q == ST_WAIT_LD) ? SEL_RDATA : wb_sel_encode(ex_memtoreg, ex_link);

  mem_wb_writeback_wb_select #(
    .DATA_W (DATA_W)
  ) u_wb_select (
    .sel_i   (sel),
    .alu_i   (ex_aluresult),
    .pc4_i   (ex_pcplus4),
    .rdata_i (mem_rdata),
    .data_o  (sel_data)
  );

  assign stall_out = (state_q == ST_WAIT_LD);
  assign accept    = ex_valid & ~flush & ~stall_out;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ld_dest_d     = ld_dest_q;
    ld_regwrite_d = ld_regwrite_q;
    wr_d          = 1'b0;
    dest_d        = dest_q;
    data_d        = data_q;
    timeout_d     = 1'b0;

    case (state_q)
      ST_IDLE, ST_WRITE: begin
        // WRITE already holds its committed result in the output registers,
        // so it accepts the next instruction exactly like IDLE.
        state_d = ST_IDLE;
        if (accept) begin
          if (ex_memtoreg) begin
            state_d       = ST_WAIT_LD;
            cnt_d         = '0;
            ld_dest_d     = ex_destadd;
            ld_regwrite_d = ex_regwrite;
          end else begin
            wr_d   = ex_regwrite & (ex_destadd != '0);
            dest_d = ex_destadd;
            data_d = sel_data;
          end
        end
      end

      ST_WAIT_LD: begin
        if (flush) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (mem_rvalid) begin
          state_d = ST_WRITE;
          cnt_d   = '0;
          wr_d    = ld_regwrite_q & (ld_dest_q != '0);
          dest_d  = ld_dest_q;
          data_d  = sel_data;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      ld_dest_q     <= '0;
      ld_regwrite_q <= 1'b0;
      wr_q          <= 1'b0;
      dest_q        <= '0;
      data_q        <= '0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ld_dest_q     <= ld_dest_d;
      ld_regwrite_q <= ld_regwrite_d;
      wr_q          <= wr_d;
      dest_q        <= dest_d;
      data_q        <= data_d;
      timeout_q     <= timeout_d;
    end
  end

  assign mem_wb_regwrite = wr_q;
  assign mem_wb_destadd  = dest_q;
  assign wb_writedata    = data_q;
  assign load_timeout    = timeout_q;

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Scoreboard bench for mem_wb_writeback: expected writes are queued when stimulus
// is driven and popped by a monitor whenever the DUT presents a register write.
module tb_mem_wb_writeback;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ex_valid, ex_regwrite, ex_memtoreg, ex_link;
  logic [AW-1:0] ex_destadd;
  logic [DW-1:0] ex_aluresult, ex_pcplus4;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic          flush;
  logic          stall_out, mem_wb_regwrite, load_timeout;
  logic [AW-1:0] mem_wb_destadd;
  logic [DW-1:0] wb_writedata;

  typedef struct packed {
    logic [AW-1:0] dest;
    logic [DW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  pulses = 0;

  always #5 clk = ~clk;

  mem_wb_writeback #(
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .TIMEOUT (TO)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ex_valid        (ex_valid),
    .ex_regwrite     (ex_regwrite),
    .ex_memtoreg     (ex_memtoreg),
    .ex_link         (ex_link),
    .ex_destadd      (ex_destadd),
    .ex_aluresult    (ex_aluresult),
    .ex_pcplus4      (ex_pcplus4),
    .mem_rvalid      (mem_rvalid),
    .mem_rdata       (mem_rdata),
    .flush           (flush),
    .stall_out       (stall_out),
    .mem_wb_regwrite (mem_wb_regwrite),
    .mem_wb_destadd  (mem_wb_destadd),
    .wb_writedata    (wb_writedata),
    .load_timeout    (load_timeout)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // Monitor: every presented write must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (load_timeout === 1'b1) begin
        pulses++;
        $display("t=%0t load_timeout pulse", $time);
      end
      if (mem_wb_regwrite === 1'b1) begin
        $display("t=%0t write r%0d = %h", $time, mem_wb_destadd, wb_writedata);
        check("wr_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_dest", 64'(mem_wb_destadd), 64'(e.dest));
          check("wr_data", 64'(wb_writedata), 64'(e.data));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [AW-1:0] d, input logic [DW-1:0] v);
    wr_t e;
    e.dest = d;
    e.data = v;
    exp_q.push_back(e);
  endtask

  task automatic nonload(input logic [AW-1:0] d, input logic [DW-1:0] alu,
                         input logic [DW-1:0] pc4, input logic link, input logic rw);
    ex_valid     = 1'b1;
    ex_memtoreg  = 1'b0;
    ex_link      = link;
    ex_regwrite  = rw;
    ex_destadd   = d;
    ex_aluresult = alu;
    ex_pcplus4   = pc4;
    if (rw && d != '0) push_wr(d, link ? pc4 : alu);
    tick();
    ex_valid = 1'b0;
  endtask

  task automatic load(input logic [AW-1:0] d);
    ex_valid    = 1'b1;
    ex_memtoreg = 1'b1;
    ex_link     = 1'b0;
    ex_regwrite = 1'b1;
    ex_destadd  = d;
    tick();
    ex_valid    = 1'b0;
    ex_memtoreg = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; ex_valid = 1'b0; ex_regwrite = 1'b0; ex_memtoreg = 1'b0;
    ex_link = 1'b0; ex_destadd = '0; ex_aluresult = '0; ex_pcplus4 = '0;
    mem_rvalid = 1'b0; mem_rdata = '0; flush = 1'b0;

    // Reset state
    #12;
    check("rst_regwrite", 64'(mem_wb_regwrite), 64'd0);
    check("rst_destadd", 64'(mem_wb_destadd), 64'd0);
    check("rst_data", 64'(wb_writedata), 64'd0);
    check("rst_stall", 64'(stall_out), 64'd0);
    check("rst_timeout", 64'(load_timeout), 64'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    tick();

    // Plain ALU result, one-cycle write
    nonload(5'd5, 32'h0000_0010, 32'h0, 1'b0, 1'b1);
    tick();
    @(negedge clk);
    check("alu_rw_drop", 64'(mem_wb_regwrite), 64'd0);

    // Load r7, rvalid 3 cycles after accept; r8 queued behind it
    load(5'd7);
    push_wr(5'd7, 32'hDEAD_BEEF);
    push_wr(5'd8, 32'h0000_0088);
    ex_valid = 1'b1; ex_memtoreg = 1'b0; ex_link = 1'b0; ex_regwrite = 1'b1;
    ex_destadd = 5'd8; ex_aluresult = 32'h0000_0088;
    @(negedge clk); check("ld_stall_w1", 64'(stall_out), 64'd1);
    tick();
    @(negedge clk); check("ld_stall_w2", 64'(stall_out), 64'd1);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk); check("ld_stall_w3", 64'(stall_out), 64'd1);
    tick();
    mem_rvalid = 1'b0;
    @(negedge clk);
    check("ld_stall_write", 64'(stall_out), 64'd0);
    check("ld_write_rw", 64'(mem_wb_regwrite), 64'd1);
    tick();
    ex_valid = 1'b0;
    tick();

    // Link result, then the same to r0 (no write)
    nonload(5'd31, 32'hAAAA_AAAA, 32'h0000_0104, 1'b1, 1'b1);
    nonload(5'd0, 32'hAAAA_AAAA, 32'h0000_0104, 1'b1, 1'b1);
    @(negedge clk);
    check("link_r0_rw", 64'(mem_wb_regwrite), 64'd0);
    tick();

    // Timeout with no rvalid
    load(5'd9);
    for (int i = 0; i < TO; i++) begin
      @(negedge clk);
      check($sformatf("to_stall_%0d", i), 64'(stall_out), 64'd1);
      check($sformatf("to_nopulse_%0d", i), 64'(load_timeout), 64'd0);
      tick();
    end
    @(negedge clk);
    check("to_pulse", 64'(load_timeout), 64'd1);
    check("to_stall_rel", 64'(stall_out), 64'd0);
    tick();
    @(negedge clk);
    check("to_pulse_end", 64'(load_timeout), 64'd0);
    tick();

    // rvalid in the timeout cycle wins
    load(5'd10);
    for (int i = 0; i < TO - 1; i++) tick();
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    push_wr(5'd10, 32'hCAFE_F00D);
    tick();
    mem_rvalid = 1'b0;
    @(negedge clk);
    check("late_rv_nopulse", 64'(load_timeout), 64'd0);
    check("late_rv_rw", 64'(mem_wb_regwrite), 64'd1);
    tick();

    // Flush in WAIT_LD, later rvalid ignored
    load(5'd11);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
    @(negedge clk);
    check("flush_idle", 64'(stall_out), 64'd0);
    tick();
    mem_rvalid = 1'b0;
    @(negedge clk);
    check("flush_no_wr", 64'(mem_wb_regwrite), 64'd0);
    nonload(5'd12, 32'h0000_1212, 32'h0, 1'b0, 1'b1);
    tick();

    // Async reset mid-WAIT_LD
    load(5'd13);
    tick();
    #2; rst_n = 1'b0; #1;
    check("arst_stall", 64'(stall_out), 64'd0);
    check("arst_rw", 64'(mem_wb_regwrite), 64'd0);
    check("arst_dest", 64'(mem_wb_destadd), 64'd0);
    check("arst_data", 64'(wb_writedata), 64'd0);
    check("arst_timeout", 64'(load_timeout), 64'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h3333_4444;
    tick();
    mem_rvalid = 1'b0;
    @(negedge clk);
    check("arst_no_wr", 64'(mem_wb_regwrite), 64'd0);
    check("arst_idle", 64'(stall_out), 64'd0);
    nonload(5'd15, 32'h0000_F00F, 32'h0, 1'b0, 1'b1);
    tick();
    tick();

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    check("pulse_count", 64'(pulses), 64'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
